ascon_round_sequencer: RTL and testbench
========================================

// Module: ascon_round_sequencer
// PURPOSE
//  Parametrised round sequencer for the ASCON permutation datapath.
//  Issues the round-constant index for p^a (12 rounds) and p^b (6/8 rounds).
//  Advances once per qualified step: edge- or level-qualified, chosen at elaboration.
//  Reports last-round, done and busy status to the ASCON control FSM.
// PARAMETERS
//  WIDTH      4   counter/nrounds width; 2**WIDTH must exceed MAX_ROUNDS (elab assert)
//  MAX_ROUNDS 12  total round-constant table depth; final index = MAX_ROUNDS-1
//  EDGE_MODE  1   1: one step per rising edge of enable_i; 0: one step per cycle enable_i=1
// PORTS
//  clock_i     in   1      single clock, all logic on posedge
//  reset_i     in   1      synchronous, active-high reset
//  init_i      in   1      synchronous clear to IDLE; priority below reset_i only
//  start_i     in   1      begin a sequence; sampled in IDLE only
//  nrounds_i   in   WIDTH  rounds to run, sampled with start_i; legal 1..MAX_ROUNDS
//  enable_i    in   1      step request from datapath
//  counter_o   out  WIDTH  current round-constant index
//  last_o      out  1      1 while RUN and counter_o == MAX_ROUNDS-1
//  busy_o      out  1      1 in RUN
//  done_o      out  1      one-cycle pulse after final step
//  err_o       out  1      one-cycle pulse on start_i with illegal nrounds_i
// BEHAVIOUR
//  Reset/init: state=IDLE, counter_o=0, enable_q=0, all flags 0.
//  - init_i has identical effect to reset_i, applied on the next posedge.
//  step = EDGE_MODE ? (enable_i & ~enable_q) : enable_i.
//  - enable_q <= enable_i every cycle in every state, so an edge seen in IDLE is consumed there.
//  FSM: IDLE -> RUN -> DONE -> IDLE
//  - IDLE, start_i=1, nrounds_i in 1..MAX_ROUNDS: counter_o <= MAX_ROUNDS-nrounds_i; go RUN.
//  - IDLE, start_i=1, nrounds_i=0 or >MAX_ROUNDS: err_o pulses next cycle; stay IDLE; counter held.
//  - start cycle: step is ignored; the first step is counted from the following cycle.
//  - RUN, step, counter_o < MAX_ROUNDS-1: counter_o <= counter_o+1.
//  - RUN, step, counter_o == MAX_ROUNDS-1: counter holds; go DONE.
//  - DONE: done_o=1 for exactly one cycle; next state IDLE; counter_o holds final value.
//  - start_i in RUN or DONE: ignored; no queuing; err_o stays 0.
//  Latency: start posedge -> busy_o=1 next cycle; final step posedge -> done_o=1 next cycle.
//  Outputs are registered or decoded from state/counter only; no combinational path from inputs.
//  Counter never wraps: it never exceeds MAX_ROUNDS-1 in any state.
//  Simultaneous events:
//  - init_i with start_i or step: init wins.
//  - reset_i overrides everything.
//  Reset or init in the middle of RUN aborts the sequence: no done_o, counter_o=0 next cycle.
//  EDGE_MODE=1 with enable_i held high for N cycles gives exactly one step.
// TESTING
//  T1 reset_i=1 two cycles -> counter_o=0, busy/last/done/err=0.
//  T2 start nrounds=12, EDGE_MODE=1, enable_i pulsed 1-cycle x12 -> counter 0..11, last_o at 11, done_o 1 cycle, IDLE.
//  T3 start nrounds=6, enable_i held high 3 cycles per pulse (EDGE_MODE=1) -> start 6, +1 per pulse only, done after 6 pulses.
//  T4 EDGE_MODE=0, nrounds=8, enable_i constant 1 -> counter 4..11 on consecutive cycles, done_o 8 cycles after start+1.
//  T5 start nrounds=0, then nrounds=13 -> err_o pulse each time, busy_o stays 0, counter unchanged.
//  T6 init_i asserted at counter=7 in RUN, same cycle as step -> counter_o=0, IDLE, no done_o; restart works.

Source files
------------

// File: rtl/ascon_round_sequencer_if.sv
// Control/status bundle between the ASCON control FSM (master) and the
// round sequencer (slave).
interface ascon_round_sequencer_if #(
  parameter int WIDTH = 4
);
  logic             init_i;
  logic             start_i;
  logic [WIDTH-1:0] nrounds_i;
  logic             enable_i;
  logic [WIDTH-1:0] counter_o;
  logic             last_o;
  logic             busy_o;
  logic             done_o;
  logic             err_o;

  modport master (
    output init_i, start_i, nrounds_i, enable_i,
    input  counter_o, last_o, busy_o, done_o, err_o
  );

  modport slave (
    input  init_i, start_i, nrounds_i, enable_i,
    output counter_o, last_o, busy_o, done_o, err_o
  );
endinterface

// File: rtl/ascon_round_sequencer.sv
// Round-constant index sequencer for the ASCON p^a / p^b permutations.
// Runs the last nrounds entries of the constant table, one per qualified step.
module ascon_round_sequencer #(
  parameter int WIDTH      = 4,
  parameter int MAX_ROUNDS = 12,
  parameter int EDGE_MODE  = 1
) (
  input  logic                  clock_i,
  input  logic                  reset_i,
  ascon_round_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] LAST_IDX = WIDTH'(MAX_ROUNDS - 1);
  localparam logic [WIDTH-1:0] MAX_CNT  = WIDTH'(MAX_ROUNDS);

  if ((2 ** WIDTH) <= MAX_ROUNDS || MAX_ROUNDS < 1) begin : g_bad_params
    $error("ascon_round_sequencer: 2**WIDTH must exceed MAX_ROUNDS and MAX_ROUNDS must be >= 1");
  end

  state_t           state_reg;
  logic [WIDTH-1:0] counter_reg;
  logic             enable_q_reg;
  logic             err_reg;
  logic             step;
  logic             nrounds_ok;

  // Edge mode turns a held-high enable into a single step.
  if (EDGE_MODE != 0) begin : g_edge_step
    assign step = bus.enable_i & ~enable_q_reg;
  end else begin : g_level_step
    assign step = bus.enable_i;
  end

  assign nrounds_ok = (bus.nrounds_i != '0) && (bus.nrounds_i <= MAX_CNT);

  always_ff @(posedge clock_i) begin
    if (reset_i || bus.init_i) begin
      state_reg    <= ST_IDLE;
      counter_reg  <= '0;
      enable_q_reg <= 1'b0;
      err_reg      <= 1'b0;
    end else begin
      enable_q_reg <= bus.enable_i;
      err_reg      <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (bus.start_i) begin
            if (nrounds_ok) begin
              counter_reg <= MAX_CNT - bus.nrounds_i;
              state_reg   <= ST_RUN;
            end else begin
              err_reg <= 1'b1;
            end
          end
        end
        ST_RUN: begin
          // The final index holds; the counter never passes MAX_ROUNDS-1.
          if (step) begin
            if (counter_reg < LAST_IDX) begin
              counter_reg <= counter_reg + 1'b1;
            end else begin
              state_reg <= ST_DONE;
            end
          end
        end
        ST_DONE: begin
          state_reg <= ST_IDLE;
        end
        default: begin
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.counter_o = counter_reg;
  assign bus.busy_o    = (state_reg == ST_RUN);
  assign bus.last_o    = (state_reg == ST_RUN) && (counter_reg == LAST_IDX);
  assign bus.done_o    = (state_reg == ST_DONE);
  assign bus.err_o     = err_reg;

endmodule

// File: tb/tb_ascon_round_sequencer.sv
// Bench for ascon_round_sequencer: edge-mode and level-mode instances share
// stimulus; vector table, directed sequences, then random run against a model.
module tb_ascon_round_sequencer;
  localparam int W  = 4;
  localparam int MR = 12;

  logic         clk   = 1'b0;
  logic         rst   = 1'b1;
  logic         init  = 1'b0;
  logic         start = 1'b0;
  logic         en    = 1'b0;
  logic [W-1:0] nr    = '0;

  int vectors = 0;
  int errors  = 0;

  always #5 clk = ~clk;

  ascon_round_sequencer_if #(.WIDTH(W)) bus_e ();
  ascon_round_sequencer_if #(.WIDTH(W)) bus_l ();

  assign bus_e.init_i    = init;
  assign bus_e.start_i   = start;
  assign bus_e.nrounds_i = nr;
  assign bus_e.enable_i  = en;
  assign bus_l.init_i    = init;
  assign bus_l.start_i   = start;
  assign bus_l.nrounds_i = nr;
  assign bus_l.enable_i  = en;

  ascon_round_sequencer #(.WIDTH(W), .MAX_ROUNDS(MR), .EDGE_MODE(1)) dut_e (
    .clock_i (clk),
    .reset_i (rst),
    .bus     (bus_e.slave)
  );

  ascon_round_sequencer #(.WIDTH(W), .MAX_ROUNDS(MR), .EDGE_MODE(0)) dut_l (
    .clock_i (clk),
    .reset_i (rst),
    .bus     (bus_l.slave)
  );

  // Reference model: a sequence is "rounds remaining" plus the table index;
  // index + remaining always equals MR while running. [0]=edge, [1]=level.
  int m_idx  [2];
  int m_left [2];
  bit m_done [2];
  bit m_err  [2];
  bit m_eq   [2];

  always @(posedge clk) begin
    bit step;
    bit was_done;
    for (int m = 0; m < 2; m++) begin
      step     = (m == 0) ? (en && !m_eq[m]) : en;
      was_done = m_done[m];
      m_done[m] = 1'b0;
      m_err[m]  = 1'b0;
      if (rst || init) begin
        m_idx[m]  = 0;
        m_left[m] = 0;
        m_eq[m]   = 1'b0;
      end else begin
        if (m_left[m] > 0) begin
          if (step) begin
            if (m_left[m] == 1) m_done[m] = 1'b1;
            else                m_idx[m]  = m_idx[m] + 1;
            m_left[m] = m_left[m] - 1;
          end
        end else if (!was_done && start) begin
          if (nr >= 1 && nr <= MR) begin
            m_idx[m]  = MR - int'(nr);
            m_left[m] = int'(nr);
          end else begin
            m_err[m] = 1'b1;
          end
        end
        m_eq[m] = en;
      end
    end
  end

  task automatic check(input string name, input int m, input int c,
                       input logic b, input logic l, input logic d, input logic e);
    logic [W-1:0] ac;
    logic ab, al, ad, ae;
    if (m == 0) begin
      ac = bus_e.counter_o; ab = bus_e.busy_o; al = bus_e.last_o;
      ad = bus_e.done_o;    ae = bus_e.err_o;
    end else begin
      ac = bus_l.counter_o; ab = bus_l.busy_o; al = bus_l.last_o;
      ad = bus_l.done_o;    ae = bus_l.err_o;
    end
    vectors++;
    if (ac !== W'(c) || ab !== b || al !== l || ad !== d || ae !== e) begin
      errors++;
      $display("FAIL %s (dut %0d) t=%0t: got ctr=%0d busy=%b last=%b done=%b err=%b, expected ctr=%0d busy=%b last=%b done=%b err=%b",
               name, m, $time, ac, ab, al, ad, ae, c, b, l, d, e);
    end
  endtask

  task automatic cyc(input logic i, input logic s, input int n, input logic e);
    init  = i;
    start = s;
    nr    = W'(n);
    en    = e;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) cyc(1'b0, 1'b0, 0, 1'b0);
    rst = 1'b0;
  endtask

  typedef struct {
    logic rst, ini, st;
    int   nr;
    logic en;
    int   c;
    logic b, l, d, e;
  } vec_t;

  vec_t tbl [19];

  initial begin
    // inputs: rst init start nrounds enable | expected: ctr busy last done err (edge DUT)
    tbl[0]  = '{1, 0, 0,  0, 0,   0, 0, 0, 0, 0};
    tbl[1]  = '{1, 0, 0,  0, 0,   0, 0, 0, 0, 0};
    tbl[2]  = '{0, 0, 1,  0, 0,   0, 0, 0, 0, 1};
    tbl[3]  = '{0, 0, 1, 13, 0,   0, 0, 0, 0, 1};
    tbl[4]  = '{0, 0, 0,  0, 0,   0, 0, 0, 0, 0};
    tbl[5]  = '{0, 0, 1,  1, 0,  11, 1, 1, 0, 0};
    tbl[6]  = '{0, 0, 0,  0, 1,  11, 0, 0, 1, 0};
    tbl[7]  = '{0, 0, 1,  2, 1,  11, 0, 0, 0, 0};
    tbl[8]  = '{0, 0, 1,  0, 1,  11, 0, 0, 0, 1};
    tbl[9]  = '{0, 0, 1,  2, 1,  10, 1, 0, 0, 0};
    tbl[10] = '{0, 0, 0,  0, 1,  10, 1, 0, 0, 0};
    tbl[11] = '{0, 0, 0,  0, 0,  10, 1, 0, 0, 0};
    tbl[12] = '{0, 0, 1,  5, 1,  11, 1, 1, 0, 0};
    tbl[13] = '{0, 0, 0,  0, 1,  11, 1, 1, 0, 0};
    tbl[14] = '{0, 0, 0,  0, 0,  11, 1, 1, 0, 0};
    tbl[15] = '{0, 1, 0,  0, 1,   0, 0, 0, 0, 0};
    tbl[16] = '{0, 0, 0,  0, 1,   0, 0, 0, 0, 0};
    tbl[17] = '{0, 0, 1, 12, 0,   0, 1, 0, 0, 0};
    tbl[18] = '{1, 0, 0,  0, 1,   0, 0, 0, 0, 0};

    for (int i = 0; i < 19; i++) begin
      rst = tbl[i].rst;
      cyc(tbl[i].ini, tbl[i].st, tbl[i].nr, tbl[i].en);
      check($sformatf("vec%0d", i), 0, tbl[i].c, tbl[i].b, tbl[i].l, tbl[i].d, tbl[i].e);
    end

    // Full p^a: twelve one-cycle pulses, index 0..11.
    do_reset();
    cyc(1'b0, 1'b1, 12, 1'b0);
    check("t2_start", 0, 0, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 12; k++) begin
      cyc(1'b0, 1'b0, 0, 1'b1);
      if (k < 11) check("t2_step", 0, k + 1, 1'b1, (k == 10), 1'b0, 1'b0);
      else        check("t2_final", 0, 11, 1'b0, 1'b0, 1'b1, 1'b0);
      cyc(1'b0, 1'b0, 0, 1'b0);
      if (k < 11) check("t2_gap", 0, k + 1, 1'b1, (k == 10), 1'b0, 1'b0);
      else        check("t2_idle", 0, 11, 1'b0, 1'b0, 1'b0, 1'b0);
    end

    // p^b with 6 rounds, enable held three cycles per pulse.
    cyc(1'b0, 1'b1, 6, 1'b0);
    check("t3_start", 0, 6, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int p = 0; p < 6; p++) begin
      cyc(1'b0, 1'b0, 0, 1'b1);
      if (p < 5) check("t3_pulse", 0, 7 + p, 1'b1, (p == 4), 1'b0, 1'b0);
      else       check("t3_done", 0, 11, 1'b0, 1'b0, 1'b1, 1'b0);
      cyc(1'b0, 1'b0, 0, 1'b1);
      cyc(1'b0, 1'b0, 0, 1'b1);
      if (p < 5) check("t3_held", 0, 7 + p, 1'b1, (p == 4), 1'b0, 1'b0);
      else       check("t3_idle", 0, 11, 1'b0, 1'b0, 1'b0, 1'b0);
      cyc(1'b0, 1'b0, 0, 1'b0);
    end

    // Level mode, 8 rounds, enable constantly high.
    do_reset();
    cyc(1'b0, 1'b1, 8, 1'b1);
    check("t4_start", 1, 4, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int k = 1; k < 8; k++) begin
      cyc(1'b0, 1'b0, 0, 1'b1);
      check("t4_run", 1, 4 + k, 1'b1, (k == 7), 1'b0, 1'b0);
    end
    cyc(1'b0, 1'b0, 0, 1'b1);
    check("t4_done", 1, 11, 1'b0, 1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 0, 1'b0);
    check("t4_idle", 1, 11, 1'b0, 1'b0, 1'b0, 1'b0);

    // Init mid-run, coincident with a step, then restart.
    do_reset();
    cyc(1'b0, 1'b1, 12, 1'b0);
    for (int k = 0; k < 7; k++) begin
      cyc(1'b0, 1'b0, 0, 1'b1);
      cyc(1'b0, 1'b0, 0, 1'b0);
    end
    check("t6_at7", 0, 7, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 0, 1'b1);
    check("t6_init", 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 0, 1'b0);
    check("t6_nodone", 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 3, 1'b0);
    check("t6_restart", 0, 9, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 0, 1'b1);
    check("t6_step", 0, 10, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 4, 1'b0);
    check("t6_init_start", 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Random traffic on both instances against the model.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      rst   = ($urandom_range(0, 199) == 0);
      init  = ($urandom_range(0, 59) == 0);
      start = ($urandom_range(0, 5) == 0);
      nr    = W'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) en = ~en;
      @(posedge clk);
      #1;
      check("rand_edge", 0, m_idx[0], (m_left[0] > 0), (m_left[0] == 1), m_done[0], m_err[0]);
      check("rand_level", 1, m_idx[1], (m_left[1] > 0), (m_left[1] == 1), m_done[1], m_err[1]);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
